// File: rtl/icap_feeder.sv
// icap_feeder: streams DMA bitstream words into ICAP with RDWRB-before-CSIB sequencing,
// timeout and short-bitstream detection. Build macro ICAP_BITSWAP_EN bit-reverses each data byte.
module icap_feeder #(
  parameter int CNT_W          = 20,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_config_start,
  input  logic [CNT_W-1:0] i_word_cnt,
  input  logic [31:0]      i_dma_data,
  input  logic             i_dma_valid,
  output logic             o_dma_ready,
  input  logic             i_dma_done,
  output logic             o_icap_csib,
  output logic             o_icap_rdwrb,
  output logic [31:0]      o_icap_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_err
);

  localparam int                 STALL_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               csib_q, csib_d;
  logic               rdwrb_q, rdwrb_d;
  logic [31:0]        data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic               xfer;
  logic               short_err;
  logic               tmo_err;

  function automatic logic [31:0] icap_word(input logic [31:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        r[8*b + k] = w[8*b + 7 - k];
      end
    end
    return r;
`else
    return w;
`endif
  endfunction

  assign o_dma_ready = (state_q == S_STREAM);
  assign xfer        = o_dma_ready && i_dma_valid;
  assign short_err   = i_dma_done && (remaining_q != '0);
  assign tmo_err     = (stall_q == STALL_LAST);

  always_comb begin
    // NOTE: every next-state value starts from its register so no path through the case infers a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    stall_d     = stall_q;
    csib_d      = csib_q;
    rdwrb_d     = rdwrb_q;
    data_d      = data_q;
    err_d       = err_q;
    busy_d      = (state_q != S_IDLE);
    done_d      = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        csib_d = 1'b1;
        if (i_config_start) begin
          if (i_word_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = i_word_cnt;
            stall_d     = '0;
            err_d       = 2'b00;
            rdwrb_d     = 1'b0;
            state_d     = S_ARM;
          end
        end
      end
      S_ARM: begin
        csib_d  = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (xfer) begin
          data_d  = icap_word(i_dma_data);
          csib_d  = 1'b0;
          stall_d = '0;
          if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = S_FLUSH;
        end else begin
          csib_d  = 1'b1;
          stall_d = stall_q + 1'b1;
          // A word offered in the same cycle as an error condition is taken instead.
          if (short_err || tmo_err) begin
            err_d   = err_q | {short_err, tmo_err};
            rdwrb_d = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_FLUSH: begin
        csib_d  = 1'b1;
        rdwrb_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        csib_d  = 1'b1;
        rdwrb_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      stall_q     <= '0;
      csib_q      <= 1'b1;
      rdwrb_q     <= 1'b1;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      stall_q     <= stall_d;
      csib_q      <= csib_d;
      rdwrb_q     <= rdwrb_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_icap_csib  = csib_q;
  assign o_icap_rdwrb = rdwrb_q;
  assign o_icap_data  = data_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule
